// File: rtl/axi_bram_pkg.sv
// Shared constants, types and helpers for the banked AXI4-Lite BRAM writer.
// Latency: none (package only).
// Backpressure: none (package only).
package axi_bram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Bank index width, never narrower than one bit so a single-bank build still has a signal.
    function automatic int bank_w(input int num_banks);
        return (clog2(num_banks) > 0) ? clog2(num_banks) : 1;
    endfunction

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_ISSUE = 2'd1,
        R_WAIT  = 2'd2,
        R_RESP  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/axi_bram_writer_banked_if.sv
// AXI4-Lite bundle between the PS interconnect and the banked BRAM writer.
// Latency: none (wiring only).
// Backpressure: carried by the ready/valid pairs of each channel.
interface axi_bram_writer_banked_if #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   awaddr;
    logic                        awvalid;
    logic                        awready;
    logic [AXI_DATA_WIDTH-1:0]   wdata;
    logic [AXI_DATA_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [AXI_ADDR_WIDTH-1:0]   araddr;
    logic                        arvalid;
    logic                        arready;
    logic [AXI_DATA_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport slave (
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

    modport master (
        output awaddr, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );
endinterface

// File: rtl/axi_bram_addr_decode.sv
// Splits a byte address into BRAM word, bank index and an in-range flag.
// Latency: combinational.
// Backpressure: none.
module axi_bram_addr_decode
    import axi_bram_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int NUM_BANKS       = 4
) (
    input  logic [AXI_ADDR_WIDTH-1:0]       addr,
    output logic [BRAM_ADDR_WIDTH-1:0]      word,
    output logic [bank_w(NUM_BANKS)-1:0]    bank,
    output logic                            in_range
);
    localparam int ADDR_LSB  = clog2(AXI_DATA_WIDTH / 8);
    localparam int BANK_BITS = clog2(NUM_BANKS);
    localparam int HI_LSB    = ADDR_LSB + BRAM_ADDR_WIDTH + BANK_BITS;

    logic [AXI_ADDR_WIDTH-1:0] hi_bits;

    assign word    = addr[ADDR_LSB +: BRAM_ADDR_WIDTH];
    // Everything above the bank field must be zero; the shift yields zero when no such bits exist.
    assign hi_bits = addr >> HI_LSB;

    generate
        if (BANK_BITS == 0) begin : g_single_bank
            assign bank = '0;
        end else begin : g_multi_bank
            assign bank = addr[ADDR_LSB + BRAM_ADDR_WIDTH +: BANK_BITS];
        end
    endgenerate

    // A non-power-of-two bank count leaves holes in the bank field that must also error.
    assign in_range = (hi_bits == '0) && (int'(bank) < NUM_BANKS);

endmodule

// File: rtl/axi_bram_writer_banked.sv
// AXI4-Lite slave writing NUM_BANKS BRAM banks over a shared port; optional read-back (AXI_BRAM_WRITER_READBACK_EN).
// Latency: AW+W handshake -> we next cycle -> bvalid the cycle after; read-back rvalid 3 cycles after AR (1 when disabled).
// Backpressure: one AW and one W held; a held pair fires only once bvalid has drained; one read in flight.
module axi_bram_writer_banked
    import axi_bram_pkg::*;
#(
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXI_ADDR_WIDTH  = 16,
    parameter int BRAM_ADDR_WIDTH = 10,
    parameter int NUM_BANKS       = 4
) (
    input  logic                                    aclk,
    input  logic                                    aresetn,
    axi_bram_writer_banked_if.slave                 s_axi,
    output logic                                    bram_porta_clk,
    output logic                                    bram_porta_rst,
    output logic [BRAM_ADDR_WIDTH-1:0]              bram_porta_addr,
    output logic [AXI_DATA_WIDTH-1:0]               bram_porta_wdata,
    output logic [NUM_BANKS*(AXI_DATA_WIDTH/8)-1:0] bram_porta_we,
    input  logic [NUM_BANKS*AXI_DATA_WIDTH-1:0]     bram_porta_rdata
);
    localparam int STRB_W = AXI_DATA_WIDTH / 8;
    localparam int BANK_W = bank_w(NUM_BANKS);

    // Write holding registers
    logic                       aw_full;
    logic                       w_full;
    logic [AXI_ADDR_WIDTH-1:0]  aw_addr;
    logic [AXI_DATA_WIDTH-1:0]  w_data;
    logic [STRB_W-1:0]          w_strb;
    logic                       bvalid_q;
    logic [1:0]                 bresp_q;
    logic                       wr_fire;

    logic [BRAM_ADDR_WIDTH-1:0] wr_word;
    logic [BANK_W-1:0]          wr_bank;
    logic                       wr_in_range;

    // Read path state
    rd_state_t                  rd_state;
    logic                       arready_q;
    logic                       rvalid_q;
    logic [1:0]                 rresp_q;
    logic [AXI_DATA_WIDTH-1:0]  rdata_q;

    assign bram_porta_clk   = aclk;
    assign bram_porta_rst   = ~aresetn;
    assign bram_porta_wdata = w_data;

    assign s_axi.awready = ~aw_full;
    assign s_axi.wready  = ~w_full;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;

    // Holding both halves while the previous response is outstanding keeps the fire cycle isolated.
    assign wr_fire = aw_full & w_full & ~bvalid_q;

    axi_bram_addr_decode #(
        .AXI_DATA_WIDTH  (AXI_DATA_WIDTH),
        .AXI_ADDR_WIDTH  (AXI_ADDR_WIDTH),
        .BRAM_ADDR_WIDTH (BRAM_ADDR_WIDTH),
        .NUM_BANKS       (NUM_BANKS)
    ) u_wr_dec (
        .addr     (aw_addr),
        .word     (wr_word),
        .bank     (wr_bank),
        .in_range (wr_in_range)
    );

    // Capture AW and W independently; both holding slots free up on the fire cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (wr_fire) begin
                aw_full <= 1'b0;
            end else if (s_axi.awvalid && !aw_full) begin
                aw_full <= 1'b1;
                aw_addr <= s_axi.awaddr;
            end
            if (wr_fire) begin
                w_full <= 1'b0;
            end else if (s_axi.wvalid && !w_full) begin
                w_full <= 1'b1;
                w_data <= s_axi.wdata;
                w_strb <= s_axi.wstrb;
            end
        end
    end

    // Write response: raised the cycle after the fire, held until the master takes it.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (wr_fire) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && s_axi.bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Byte enables steered onto the decoded bank's slice during the fire cycle only.
    always_comb begin
        bram_porta_we = '0;
        if (wr_fire && wr_in_range) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                if (wr_bank == BANK_W'(k)) begin
                    bram_porta_we[k*STRB_W +: STRB_W] = w_strb;
                end
            end
        end
    end

`ifdef AXI_BRAM_WRITER_READBACK_EN
    logic [AXI_ADDR_WIDTH-1:0]  ar_addr;
    logic [BRAM_ADDR_WIDTH-1:0] rd_word;
    logic [BANK_W-1:0]          rd_bank;
    logic                       rd_in_range;
    logic [AXI_DATA_WIDTH-1:0]  rd_slice;

    axi_bram_addr_decode #(
        .AXI_DATA_WIDTH  (AXI_DATA_WIDTH),
        .AXI_ADDR_WIDTH  (AXI_ADDR_WIDTH),
        .BRAM_ADDR_WIDTH (BRAM_ADDR_WIDTH),
        .NUM_BANKS       (NUM_BANKS)
    ) u_rd_dec (
        .addr     (ar_addr),
        .word     (rd_word),
        .bank     (rd_bank),
        .in_range (rd_in_range)
    );

    // A firing write owns the shared port; the read address goes out on the next free cycle.
    always_comb begin
        bram_porta_addr = wr_word;
        if (!wr_fire && rd_state == R_ISSUE) begin
            bram_porta_addr = rd_word;
        end
    end

    // Select the addressed bank's read data.
    always_comb begin
        rd_slice = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (rd_bank == BANK_W'(k)) begin
                rd_slice = bram_porta_rdata[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end
    end

    // Read FSM: issue address, wait one BRAM cycle, capture and hold the response.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            ar_addr   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (s_axi.arvalid) begin
                        ar_addr   <= s_axi.araddr;
                        arready_q <= 1'b0;
                        rd_state  <= R_ISSUE;
                    end
                end
                R_ISSUE: begin
                    if (!wr_fire) begin
                        rd_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= rd_in_range ? rd_slice : '0;
                    rresp_q  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
                    rd_state <= R_RESP;
                end
                R_RESP: begin
                    if (s_axi.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_state  <= R_IDLE;
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end
`else
    // Read-back is not built: the port only ever carries write addresses.
    logic unused_rd;
    assign unused_rd       = ^{bram_porta_rdata, s_axi.araddr};
    assign bram_porta_addr = wr_word;

    // Every read completes immediately with a zero payload and SLVERR.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (s_axi.arvalid) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= '0;
                        rresp_q   <= RESP_SLVERR;
                        rd_state  <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_axi.rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        rd_state  <= R_IDLE;
                    end
                end
                default: begin
                    rd_state <= R_IDLE;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_axi_bram_writer_banked.sv
// Self-checking bench for axi_bram_writer_banked with a behavioural BRAM and a reference memory model.
// Latency: n/a.
// Backpressure: bench drives bready/rready explicitly per scenario.
module tb_axi_bram_writer_banked;

    localparam int NB    = 4;
    localparam int WORDS = 1024;
`ifdef AXI_BRAM_WRITER_READBACK_EN
    localparam int RD_LAT = 3;
`else
    localparam int RD_LAT = 1;
`endif

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic                 bram_porta_clk;
    logic                 bram_porta_rst;
    logic [9:0]           bram_porta_addr;
    logic [31:0]          bram_porta_wdata;
    logic [NB*4-1:0]      bram_porta_we;
    logic [NB*32-1:0]     bram_porta_rdata;

    axi_bram_writer_banked_if #(.AXI_ADDR_WIDTH(16), .AXI_DATA_WIDTH(32)) s_axi ();

    axi_bram_writer_banked #(
        .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .BRAM_ADDR_WIDTH(10), .NUM_BANKS(NB)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_axi            (s_axi),
        .bram_porta_clk   (bram_porta_clk),
        .bram_porta_rst   (bram_porta_rst),
        .bram_porta_addr  (bram_porta_addr),
        .bram_porta_wdata (bram_porta_wdata),
        .bram_porta_we    (bram_porta_we),
        .bram_porta_rdata (bram_porta_rdata)
    );

    int checks = 0;
    int errors = 0;

    // Environment BRAMs: byte-enabled write, 1-cycle registered read.
    logic [31:0] bram_mem [NB][WORDS];
    logic [31:0] bram_rd  [NB];
    bit          mem_ready = 1'b0;
    always @(posedge aclk) begin
        if (!mem_ready) begin
            for (int b = 0; b < NB; b++)
                for (int w = 0; w < WORDS; w++)
                    bram_mem[b][w] <= '0;
            mem_ready <= 1'b1;
        end else begin
            for (int b = 0; b < NB; b++) begin
                for (int j = 0; j < 4; j++)
                    if (bram_porta_we[b*4+j])
                        bram_mem[b][bram_porta_addr][8*j +: 8] <= bram_porta_wdata[8*j +: 8];
                bram_rd[b] <= bram_mem[b][bram_porta_addr];
            end
        end
    end
    assign bram_porta_rdata = {bram_rd[3], bram_rd[2], bram_rd[1], bram_rd[0]};

    int we_cycles = 0;
    always @(posedge aclk) if (|bram_porta_we) we_cycles++;

    // Reference model: flat byte-addressed space split into NB banks of WORDS 32-bit words.
    logic [31:0] ref_mem [NB][WORDS];
    logic [15:0] touched [$];

    function automatic bit ref_in_range(input logic [15:0] a);
        return int'(a) < NB * WORDS * 4;
    endfunction

    task automatic ref_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        int b;
        int w;
        if (ref_in_range(a)) begin
            b = (int'(a) / 4) / WORDS;
            w = (int'(a) / 4) % WORDS;
            for (int j = 0; j < 4; j++)
                if (s[j]) ref_mem[b][w][8*j +: 8] = d[8*j +: 8];
            touched.push_back(a);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [15:0] a);
        if (!ref_in_range(a)) return 32'h0;
        return ref_mem[(int'(a) / 4) / WORDS][(int'(a) / 4) % WORDS];
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_done = 1'b0;
        bit w_done  = 1'b0;
        bit aw_hs;
        bit w_hs;
        int cyc = 0;
        s_axi.awaddr = a;
        s_axi.wdata  = d;
        s_axi.wstrb  = s;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_axi.awvalid = !aw_done && cyc >= aw_dly;
            s_axi.wvalid  = !w_done && cyc >= w_dly;
            aw_hs = s_axi.awvalid && s_axi.awready;
            w_hs  = s_axi.wvalid && s_axi.wready;
            tick();
            if (aw_hs) aw_done = 1'b1;
            if (w_hs)  w_done = 1'b1;
            cyc++;
        end
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        cyc = 0;
        while (!s_axi.bvalid && cyc < 50) begin
            tick();
            cyc++;
        end
        checks++;
        if (s_axi.bvalid !== 1'b1) begin
            errors++;
            $display("FAIL write_timeout addr=%h: bvalid=%b required 1", a, s_axi.bvalid);
        end
        resp = s_axi.bresp;
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp,
                            output int lat);
        int cyc = 0;
        s_axi.araddr  = a;
        s_axi.arvalid = 1'b1;
        while (!s_axi.arready && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        s_axi.arvalid = 1'b0;
        lat = 1;
        while (!s_axi.rvalid && lat < 50) begin
            tick();
            lat++;
        end
        checks++;
        if (s_axi.rvalid !== 1'b1) begin
            errors++;
            $display("FAIL read_timeout addr=%h: rvalid=%b required 1", a, s_axi.rvalid);
        end
        d    = s_axi.rdata;
        resp = s_axi.rresp;
        s_axi.rready = 1'b1;
        tick();
        s_axi.rready = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) tick();
        checks++;
        if ({s_axi.awready, s_axi.wready, s_axi.arready, s_axi.bvalid, s_axi.rvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_handshake: aw/w/ar/b/r=%b required 11100",
                     {s_axi.awready, s_axi.wready, s_axi.arready, s_axi.bvalid, s_axi.rvalid});
        end
        checks++;
        if ({bram_porta_we, s_axi.bresp, s_axi.rresp, s_axi.rdata, bram_porta_rst} !== {52'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: we=%h bresp=%b rresp=%b rdata=%h rst=%b",
                     bram_porta_we, s_axi.bresp, s_axi.rresp, s_axi.rdata, bram_porta_rst);
        end
        aresetn = 1'b1;
        tick();
        // Pending write caught in its fire cycle by a new reset.
        s_axi.awaddr = 16'h0000; s_axi.wdata = 32'hA5A5A5A5; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        checks++;
        if (bram_porta_we !== 16'h000F) begin
            errors++;
            $display("FAIL reset_prefire_we: got %h required 000f", bram_porta_we);
        end
        aresetn = 1'b0;
        #1;
        checks++;
        if (bram_porta_we !== 16'h0) begin
            errors++;
            $display("FAIL reset_async_we: got %h required 0000", bram_porta_we);
        end
        repeat (2) tick();
        aresetn = 1'b1;
        repeat (3) tick();
        checks++;
        if ({s_axi.awready, s_axi.wready, s_axi.arready, s_axi.bvalid, s_axi.rvalid, bram_porta_rst} !== 6'b111000) begin
            errors++;
            $display("FAIL reset_release: aw/w/ar/b/r/rst=%b required 111000",
                     {s_axi.awready, s_axi.wready, s_axi.arready, s_axi.bvalid, s_axi.rvalid, bram_porta_rst});
        end
        checks++;
        if (we_cycles !== 0 || bram_mem[0][0] !== ref_read(16'h0000)) begin
            errors++;
            $display("FAIL reset_dropped_write: we_cycles=%0d mem=%h required 0 and %h",
                     we_cycles, bram_mem[0][0], ref_read(16'h0000));
        end
    endtask

    task automatic test_same_cycle();
        s_axi.awaddr = 16'h1004; s_axi.wdata = 32'hDEADBEEF; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        ref_write(16'h1004, 32'hDEADBEEF, 4'hF);
        checks++;
        if (bram_porta_we !== 16'h00F0 || bram_porta_addr !== 10'd1 || bram_porta_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL same_cycle_fire: we=%h addr=%h wdata=%h required 00f0 001 deadbeef",
                     bram_porta_we, bram_porta_addr, bram_porta_wdata);
        end
        tick();
        checks++;
        if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== 2'b00 || bram_porta_we !== 16'h0) begin
            errors++;
            $display("FAIL same_cycle_bresp: bvalid=%b bresp=%b we=%h required 1 00 0000",
                     s_axi.bvalid, s_axi.bresp, bram_porta_we);
        end
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
    endtask

    task automatic test_split();
        s_axi.wdata = 32'h12345678; s_axi.wstrb = 4'h3; s_axi.wvalid = 1'b1;
        tick();
        s_axi.wvalid = 1'b0;
        checks++;
        if (s_axi.wready !== 1'b0 || s_axi.awready !== 1'b1) begin
            errors++;
            $display("FAIL split_wready: wready=%b awready=%b required 0 1", s_axi.wready, s_axi.awready);
        end
        repeat (2) tick();
        s_axi.awaddr = 16'h0008; s_axi.awvalid = 1'b1;
        tick();
        s_axi.awvalid = 1'b0;
        ref_write(16'h0008, 32'h12345678, 4'h3);
        checks++;
        if (bram_porta_we !== 16'h0003 || bram_porta_addr !== 10'd2 || bram_porta_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL split_fire: we=%h addr=%h wdata=%h required 0003 002 12345678",
                     bram_porta_we, bram_porta_addr, bram_porta_wdata);
        end
        tick();
        // Second write accepted while the first response is stalled, but must not fire.
        s_axi.awaddr = 16'h0010; s_axi.wdata = 32'h11111111; s_axi.wstrb = 4'hF;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== 2'b00 || bram_porta_we !== 16'h0) begin
                errors++;
                $display("FAIL split_bhold cycle %0d: bvalid=%b bresp=%b we=%h required 1 00 0000",
                         i, s_axi.bvalid, s_axi.bresp, bram_porta_we);
            end
            tick();
            s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0;
        end
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
        ref_write(16'h0010, 32'h11111111, 4'hF);
        checks++;
        if (bram_porta_we !== 16'h000F || bram_porta_addr !== 10'd4) begin
            errors++;
            $display("FAIL split_second_fire: we=%h addr=%h required 000f 004", bram_porta_we, bram_porta_addr);
        end
        tick();
        checks++;
        if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== 2'b00) begin
            errors++;
            $display("FAIL split_second_bresp: bvalid=%b bresp=%b required 1 00", s_axi.bvalid, s_axi.bresp);
        end
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [1:0]  resp;
        logic [31:0] d;
        int          lat;
        int          we0;
        we0 = we_cycles;
        axi_write(16'h4000, 32'hFFFFFFFF, 4'hF, 0, 0, resp);
        checks++;
        if (resp !== 2'b10 || we_cycles !== we0) begin
            errors++;
            $display("FAIL oor_write: bresp=%b we_cycles=%0d required 10 %0d", resp, we_cycles, we0);
        end
        axi_read(16'h8000, d, resp, lat);
        checks++;
        if (d !== 32'h0 || resp !== 2'b10 || lat !== RD_LAT) begin
            errors++;
            $display("FAIL oor_read: rdata=%h rresp=%b lat=%0d required 0 10 %0d", d, resp, lat, RD_LAT);
        end
    endtask

`ifdef AXI_BRAM_WRITER_READBACK_EN
    task automatic test_readback();
        logic [1:0]  resp;
        logic [31:0] d;
        int          lat;
        axi_write(16'h0C10, 32'hCAFEF00D, 4'hF, 0, 0, resp);
        ref_write(16'h0C10, 32'hCAFEF00D, 4'hF);
        axi_read(16'h0C10, d, resp, lat);
        checks++;
        if (d !== ref_read(16'h0C10) || resp !== 2'b00 || lat !== 3) begin
            errors++;
            $display("FAIL readback: rdata=%h rresp=%b lat=%0d required %h 00 3", d, resp, lat, ref_read(16'h0C10));
        end
        // AR lands together with AW/W so the read meets the write fire cycle.
        s_axi.awaddr = 16'h0C10; s_axi.wdata = 32'h0BADC0DE; s_axi.wstrb = 4'hF;
        s_axi.araddr = 16'h0C10;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.arvalid = 1'b1; s_axi.bready = 1'b1;
        tick();
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.arvalid = 1'b0;
        ref_write(16'h0C10, 32'h0BADC0DE, 4'hF);
        lat = 1;
        while (!s_axi.rvalid && lat < 50) begin
            tick();
            lat++;
        end
        s_axi.bready = 1'b0;
        checks++;
        if (s_axi.rdata !== ref_read(16'h0C10) || s_axi.rresp !== 2'b00 || lat !== 4) begin
            errors++;
            $display("FAIL readback_stall: rdata=%h rresp=%b lat=%0d required %h 00 4",
                     s_axi.rdata, s_axi.rresp, lat, ref_read(16'h0C10));
        end
        s_axi.rready = 1'b1;
        tick();
        s_axi.rready = 1'b0;
    endtask
`else
    task automatic test_readback_off();
        s_axi.araddr = 16'h0000; s_axi.arvalid = 1'b1;
        tick();
        s_axi.arvalid = 1'b0;
        checks++;
        if (s_axi.rvalid !== 1'b1 || s_axi.rdata !== 32'h0 || s_axi.rresp !== 2'b10) begin
            errors++;
            $display("FAIL rb_off_resp: rvalid=%b rdata=%h rresp=%b required 1 0 10",
                     s_axi.rvalid, s_axi.rdata, s_axi.rresp);
        end
        repeat (3) tick();
        checks++;
        if (s_axi.rvalid !== 1'b1 || s_axi.arready !== 1'b0) begin
            errors++;
            $display("FAIL rb_off_hold: rvalid=%b arready=%b required 1 0", s_axi.rvalid, s_axi.arready);
        end
        s_axi.rready = 1'b1;
        tick();
        s_axi.rready = 1'b0;
        checks++;
        if (s_axi.rvalid !== 1'b0 || s_axi.arready !== 1'b1) begin
            errors++;
            $display("FAIL rb_off_release: rvalid=%b arready=%b required 0 1", s_axi.rvalid, s_axi.arready);
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [1:0]  resp;
        int          lat;
        int          we0;
        int          exp_we = 0;
        we0 = we_cycles;
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom_range(0, 16'h4FFF)) & 16'hFFFC;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), resp);
            ref_write(a, d, s);
            if (ref_in_range(a) && s != 4'h0) exp_we++;
            checks++;
            if (resp !== (ref_in_range(a) ? 2'b00 : 2'b10)) begin
                errors++;
                $display("FAIL rand_bresp addr=%h: got %b required %b", a, resp, ref_in_range(a) ? 2'b00 : 2'b10);
            end
`ifdef AXI_BRAM_WRITER_READBACK_EN
            if (i % 4 == 3 && touched.size() > 0) begin
                a = touched[$urandom_range(0, touched.size() - 1)];
                axi_read(a, d, resp, lat);
                checks++;
                if (d !== ref_read(a) || resp !== 2'b00 || lat !== 3) begin
                    errors++;
                    $display("FAIL rand_read addr=%h: rdata=%h rresp=%b lat=%0d required %h 00 3",
                             a, d, resp, lat, ref_read(a));
                end
            end
`endif
        end
        checks++;
        if (we_cycles - we0 !== exp_we) begin
            errors++;
            $display("FAIL rand_we_count: got %0d required %0d", we_cycles - we0, exp_we);
        end
        foreach (touched[k]) begin
            a = touched[k];
            checks++;
            if (bram_mem[(int'(a) / 4) / WORDS][(int'(a) / 4) % WORDS] !== ref_read(a)) begin
                errors++;
                $display("FAIL mem_contents addr=%h: got %h required %h",
                         a, bram_mem[(int'(a) / 4) / WORDS][(int'(a) / 4) % WORDS], ref_read(a));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int b = 0; b < NB; b++)
            for (int w = 0; w < WORDS; w++)
                ref_mem[b][w] = '0;
        s_axi.awaddr = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0;
        s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arvalid = 1'b0;
        s_axi.rready = 1'b0;
        test_reset();
        test_same_cycle();
        test_split();
        test_out_of_range();
`ifdef AXI_BRAM_WRITER_READBACK_EN
        test_readback();
`else
        test_readback_off();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
